uart_receiver: RTL

//  Serial-to-parallel UART receive path; consumes the line driven by the transmit stage's serial_data_out.

---
 rtl/uart_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-FF line synchronizer, oversampling frame FSM and a
// first-word fall-through FIFO, with sticky line/FIFO error flags.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int DATA_SIZE  = 8,
    parameter int SIZE_FIFO  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 serial_data_in,
    input  logic                 read_data,
    input  logic                 clear_status,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [7:0]           status_register
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_SIZE + 1);
    localparam int ADDR_W = $clog2(SIZE_FIFO);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_reg;
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic [TICK_W-1:0]    tick_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [ADDR_W:0]      wr_ptr_reg;
    logic [ADDR_W:0]      rd_ptr_reg;
    logic [DATA_SIZE-1:0] fifo_mem [SIZE_FIFO];
    logic                 error_read_reg;
    logic                 framing_reg;
    logic                 overrun_reg;

    logic fifo_empty;
    logic fifo_full;
    logic stop_sample;
    logic pop;
    logic push;

    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                         (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign stop_sample = sample_tick && (state_reg == STOP) && (tick_cnt_reg == TICK_LAST);
    assign pop         = read_data && !fifo_empty;
    // A pop in the same clk frees a slot, so a full FIFO can still take the word.
    assign push        = stop_sample && rx_s_reg && (!fifo_full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= serial_data_in;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else if (sample_tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg    <= START;
                        tick_cnt_reg <= '0;
                    end
                end
                START: begin
                    if (tick_cnt_reg == TICK_MID) begin
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= rx_s_reg ? IDLE : DATA;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_reg <= '0;
                        shift_reg    <= {rx_s_reg, shift_reg[DATA_SIZE-1:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == BIT_LAST)
                            state_reg <= STOP;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[ADDR_W-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Clear is applied first so a same-clk set event keeps its bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_read_reg <= 1'b0;
            framing_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            error_read_reg <= (read_data && fifo_empty) || (error_read_reg && !clear_status);
            framing_reg    <= (stop_sample && !rx_s_reg) || (framing_reg && !clear_status);
            overrun_reg    <= (stop_sample && rx_s_reg && fifo_full && !pop) ||
                              (overrun_reg && !clear_status);
        end
    end

    assign data_out        = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[ADDR_W-1:0]];
    assign status_register = {3'b000, overrun_reg, framing_reg, fifo_empty, fifo_full, error_read_reg};

endmodule
